bit_match_counter: RTL and testbench
====================================

Name: bit_match_counter

Overview:
- Downstream consumer of the xnor_gate equality output.
- Takes a stream of per-bit equality results (1 = bits equal, 0 = differ) over a valid/ready handshake and groups them into frames of FRAME_LEN bits.
- At the end of each frame, reports the match count, the mismatch count, an all-match flag and the index of the first mismatch.
- Sits between the bitwise compare stage and the self-check/report logic.

Parameters:
- FRAME_LEN, 8, number of equality bits per frame; must be >= 2.
- IDX_W, $clog2(FRAME_LEN), width of the bit-index counter and of first_mis_idx.
- CNT_W, $clog2(FRAME_LEN+1), width of the count outputs; must hold the value FRAME_LEN.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  eq_bit is valid this cycle
- eq_bit  input  1  equality result from xnor_gate (y)
- in_ready  output  1  block accepts a beat this cycle
- abort  input  1  discard the partial frame
- out_valid  output  1  frame result available
- out_ready  input  1  consumer takes the result
- match_cnt  output  CNT_W  number of eq_bit=1 in the frame
- mismatch_cnt  output  CNT_W  number of eq_bit=0 in the frame
- all_match  output  1  1 when mismatch_cnt==0
- first_mis_idx  output  IDX_W  index (0 = first beat) of the first eq_bit=0; 0 when all_match=1

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high. All state updates on the rising edge of clk.
- Reset (rst=1 at an edge):
  - State goes to COLLECT.
  - bit index, match/mismatch accumulators and first-mismatch tracking clear to 0.
  - out_valid=0, match_cnt=0, mismatch_cnt=0, all_match=0, first_mis_idx=0.
  - A beat presented in the same cycle as rst is discarded.
  - Reset mid-frame or mid-REPORT drops all frame data; no result is emitted.
- in_ready = (state==COLLECT), combinational from state only. Accept = in_valid && in_ready && !abort.
- State COLLECT (in_ready=1, out_valid=0):
  - On accept: bit index +1; match accumulator +1 if eq_bit=1, else mismatch accumulator +1.
  - On the first eq_bit=0 of the frame, latch the current index as the first-mismatch index; later zeros do not change it.
  - When the accepted beat is at index FRAME_LEN-1, include that beat in the outputs and go to REPORT at the next edge.
  - Registers then present: match_cnt, mismatch_cnt, all_match, first_mis_idx, out_valid=1.
  - Latency: out_valid rises 1 cycle after the last beat is accepted.
  - The bit index never reaches FRAME_LEN; it wraps to 0 on entry to REPORT.
- abort in COLLECT: clears the index and accumulators at the next edge. A beat in the same cycle as abort is not accepted and is not counted. Stay in COLLECT.
- State REPORT (in_ready=0, out_valid=1):
  - Outputs hold stable while out_ready=0.
  - abort is ignored in REPORT.
  - On out_valid && out_ready: out_valid=0 at the next edge, accumulators already cleared, return to COLLECT. in_ready=1 in the cycle after the handshake; no beat is accepted in the handshake cycle.
  - Output data registers keep the last frame's values after out_valid drops, until the next frame completes.
- Invariant: match_cnt + mismatch_cnt == FRAME_LEN whenever out_valid=1.
- in_valid gaps (in_valid=0) in COLLECT are allowed and do not advance the index.

Test Plan:
- FRAME_LEN=8; reset 2 cycles, then 8 beats of eq_bit=1 with no gaps -> out_valid=1 one cycle after the 8th beat; match_cnt=8, mismatch_cnt=0, all_match=1, first_mis_idx=0.
- Beats 1,1,0,1,0,0,1,1 with in_valid gaps after beats 2 and 5 -> match_cnt=5, mismatch_cnt=3, all_match=0, first_mis_idx=2.
- Complete a frame, hold out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, no beats counted, outputs stable; out_ready=1 -> out_valid=0 next cycle, in_ready=1.
- Send 3 beats of 0, then assert abort together with in_valid=1 eq_bit=0, then 8 beats of 1 -> aborted beat not counted; result is match_cnt=8, all_match=1, first_mis_idx=0.
- Assert rst after 5 beats, then send 8 beats of 0 -> no output from the partial frame; result is mismatch_cnt=8, first_mis_idx=0, all_match=0.
- Drive 4 back-to-back frames with random eq_bit and random out_ready backpressure -> a scoreboard model matches every count and index, and match_cnt+mismatch_cnt==8 on every result.

Source files
------------

// File: rtl/bit_match_counter.sv
`default_nettype none
// ============================================================================
// Module      : bit_match_counter
// Description : Groups a stream of per-bit equality results into frames of
//               FRAME_LEN beats and reports match/mismatch counts, an
//               all-match flag and the index of the first mismatching beat.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_match_counter #(
  parameter int FRAME_LEN = 8,
  parameter int IDX_W     = $clog2(FRAME_LEN),
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             eq_bit,
  output logic             in_ready,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             all_match,
  output logic [IDX_W-1:0] first_mis_idx
);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    REPORT  = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             last_beat;
  logic [IDX_W-1:0] bit_idx;
  logic [IDX_W-1:0] mis_idx;
  logic             mis_seen;
  logic [CNT_W-1:0] acc_match;
  logic [CNT_W-1:0] acc_mis;
  logic [CNT_W-1:0] eq_inc;
  logic [CNT_W-1:0] ne_inc;

  // Handshake flags depend on state only, so neither side sees a comb loop.
  assign in_ready  = (state == COLLECT);
  assign out_valid = (state == REPORT);

  // An abort cycle never counts as a beat, even with in_valid high.
  assign accept    = in_valid && in_ready && !abort;
  assign last_beat = accept && (bit_idx == LAST_IDX);
  assign eq_inc    = CNT_W'(eq_bit);
  assign ne_inc    = CNT_W'(!eq_bit);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: leave COLLECT on the final beat, leave REPORT on handshake.
  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (last_beat) state_next = REPORT;
      REPORT:  if (out_ready) state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  // Frame accumulators; cleared on reset, abort, and when a frame completes.
  always_ff @(posedge clk) begin
    if (rst || (in_ready && abort) || last_beat) begin
      bit_idx   <= '0;
      acc_match <= '0;
      acc_mis   <= '0;
      mis_seen  <= 1'b0;
      mis_idx   <= '0;
    end else if (accept) begin
      bit_idx   <= bit_idx + IDX_W'(1);
      acc_match <= acc_match + eq_inc;
      acc_mis   <= acc_mis + ne_inc;
      if (!eq_bit && !mis_seen) begin
        mis_seen <= 1'b1;
        mis_idx  <= bit_idx;
      end
    end
  end

  // Result registers: load the final totals (including the last beat) and
  // hold them until the next frame completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_cnt     <= '0;
      mismatch_cnt  <= '0;
      all_match     <= 1'b0;
      first_mis_idx <= '0;
    end else if (last_beat) begin
      match_cnt     <= acc_match + eq_inc;
      mismatch_cnt  <= acc_mis + ne_inc;
      all_match     <= (acc_mis == '0) && eq_bit;
      first_mis_idx <= mis_seen ? mis_idx : (eq_bit ? '0 : bit_idx);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bit_match_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_match_counter
// Description : Randomised and directed bench for bit_match_counter with a
//               frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_match_counter;

  localparam int FRAME_LEN = 8;
  localparam int IDX_W     = $clog2(FRAME_LEN);
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             eq_bit;
  logic             in_ready;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] mismatch_cnt;
  logic             all_match;
  logic [IDX_W-1:0] first_mis_idx;

  int errors = 0;
  int checks = 0;

  // Reference model: accepted beats of the open frame plus the held result.
  bit beats[$];
  bit collecting = 1'b1;
  int exp_match  = 0;
  int exp_mis    = 0;
  bit exp_all    = 1'b0;
  int exp_first  = 0;
  int acks       = 0;

  bit_match_counter #(.FRAME_LEN(FRAME_LEN)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .eq_bit        (eq_bit),
    .in_ready      (in_ready),
    .abort         (abort),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .match_cnt     (match_cnt),
    .mismatch_cnt  (mismatch_cnt),
    .all_match     (all_match),
    .first_mis_idx (first_mis_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Evaluate a completed frame from its list of beats.
  task automatic finish_frame();
    exp_match = 0;
    exp_first = -1;
    foreach (beats[i]) begin
      if (beats[i]) exp_match++;
      else if (exp_first < 0) exp_first = i;
    end
    exp_mis = FRAME_LEN - exp_match;
    exp_all = (exp_mis == 0);
    if (exp_first < 0) exp_first = 0;
    beats.delete();
  endtask

  // One clock: compare outputs at the falling edge, then drive inputs for the
  // next rising edge and advance the model accordingly.
  task automatic step(input bit v, input bit e, input bit a, input bit r, input bit rs);
    @(negedge clk);
    check("in_ready", in_ready, collecting);
    check("out_valid", out_valid, !collecting);
    check("match_cnt", match_cnt, exp_match);
    check("mismatch_cnt", mismatch_cnt, exp_mis);
    check("all_match", all_match, exp_all);
    check("first_mis_idx", first_mis_idx, exp_first);
    if (out_valid === 1'b1)
      check("sum_invariant", 32'(match_cnt) + 32'(mismatch_cnt), FRAME_LEN);
    in_valid  = v;
    eq_bit    = e;
    abort     = a;
    out_ready = r;
    rst       = rs;
    if (rs) begin
      collecting = 1'b1;
      beats.delete();
      exp_match = 0; exp_mis = 0; exp_all = 1'b0; exp_first = 0;
    end else if (collecting) begin
      if (a) beats.delete();
      else if (v) begin
        beats.push_back(e);
        if (beats.size() == FRAME_LEN) begin
          finish_frame();
          collecting = 1'b0;
        end
      end
    end else if (r) begin
      collecting = 1'b1;
      acks++;
    end
  endtask

  task automatic idle(input bit r);
    step(1'b0, 1'b0, 1'b0, r, 1'b0);
  endtask

  initial begin
    bit pattern [8] = '{1, 1, 0, 1, 0, 0, 1, 1};
    int n;
    in_valid = 0; eq_bit = 0; abort = 0; out_ready = 0; rst = 1;
    @(posedge clk);

    // Reset for two cycles; a beat alongside reset is discarded.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Eight matching beats back to back.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check("t1_out_valid", out_valid, 1);
    check("t1_match", match_cnt, 8);
    check("t1_all", all_match, 1);
    idle(1'b1);
    idle(1'b0);

    // Mixed pattern with gaps after beats 2 and 5.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, pattern[i], 1'b0, 1'b0, 1'b0);
      if (i == 1 || i == 4) idle(1'b0);
    end
    idle(1'b0);
    check("t2_match", match_cnt, 5);
    check("t2_mis", mismatch_cnt, 3);
    check("t2_first", first_mis_idx, 2);
    check("t2_all", all_match, 0);

    // Backpressure: beats offered during REPORT are ignored.
    for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b0);
    check("t3_in_ready", in_ready, 1);

    // Abort after three mismatches, with a beat on the abort cycle.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check("t4_match", match_cnt, 8);
    check("t4_first", first_mis_idx, 0);
    idle(1'b1);

    // Reset mid-frame, then a frame of all mismatches.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check("t5_mis", mismatch_cnt, 8);
    check("t5_first", first_mis_idx, 0);
    check("t5_all", all_match, 0);
    idle(1'b1);

    // Random traffic until four more frames have been handed off.
    acks = 0;
    n = 0;
    while (acks < 4 && n < 2000) begin
      step(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 15) == 0),
           1'($urandom), 1'b0);
      n++;
    end
    check("rand_frames_done", (acks >= 4), 1);
    idle(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
